// File: rtl/noc_pkg.sv
// Shared NoC definitions: datapath widths, injection-arbiter state encoding and the flit record.
package noc_pkg;

  localparam int NOC_FLIT_W    = 16;
  localparam int NOC_NODE_ID_W = 6;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [NOC_FLIT_W-1:0]    data;
    logic                     last;
    logic [NOC_NODE_ID_W-1:0] dest;
  } flit_t;

  // Index of the set bit in a one-hot vector of up to 8 requesters.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/noc_inject_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: the first requester after last_grant (wrapping) wins.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] winner
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Wormhole round-robin arbiter sharing one router injection port, with a registered
// output stage and a per-packet flit watchdog that truncates runaway packets.
//
//   state  | meaning
//   IDLE   | no owner; arbitrate among valid requesters this cycle
//   LOCKED | grant held by one requester until its tail (or truncation) is accepted
module noc_inject_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int FLIT_W    = NOC_FLIT_W,
  parameter int NODE_ID_W = NOC_NODE_ID_W,
  parameter int MAX_FLITS = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*FLIT_W-1:0]    req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*NODE_ID_W-1:0] req_dest,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [FLIT_W-1:0]            data_out,
  output logic [NODE_ID_W-1:0]         dest_out,
  output logic                         last_out,
  output logic                         valid_out,
  input  logic                         ready_out,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         err_trunc
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_FLITS + 1);

  arb_state_t           state, state_nxt;
  logic [IW-1:0]        owner;
  logic [IW-1:0]        last_grant;
  logic [IW-1:0]        win_idx;
  logic [NUM_REQ-1:0]   winner;
  logic [NODE_ID_W-1:0] dest_reg;
  logic [CW-1:0]        flit_cnt;
  logic                 out_free;
  logic                 accept;
  logic                 at_max;
  logic                 trunc;
  logic                 release_pkt;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req        (req_valid),
    .last_grant (last_grant),
    .winner     (winner)
  );

  assign win_idx = IW'(onehot_to_idx(8'(winner)));

  always_comb begin
    out_free    = !valid_out || ready_out;
    accept      = (state == LOCKED) && req_valid[owner] && out_free;
    at_max      = (flit_cnt == CW'(MAX_FLITS - 1));
    trunc       = accept && !req_last[owner] && at_max;
    release_pkt = accept && (req_last[owner] || at_max);
    req_ready   = '0;
    if (state == LOCKED && out_free) req_ready = grant;
    state_nxt = state;
    case (state)
      IDLE:    if (|req_valid) state_nxt = LOCKED;
      LOCKED:  if (release_pkt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      dest_reg   <= '0;
      flit_cnt   <= '0;
      data_out   <= '0;
      dest_out   <= '0;
      last_out   <= 1'b0;
      valid_out  <= 1'b0;
      err_trunc  <= 1'b0;
    end else begin
      state     <= state_nxt;
      err_trunc <= trunc;
      if (state == IDLE && |req_valid) begin
        grant    <= winner;
        owner    <= win_idx;
        dest_reg <= req_dest[win_idx*NODE_ID_W +: NODE_ID_W];
        flit_cnt <= '0;
      end
      // Output register may still hold the previous tail while a new owner is picked.
      if (accept) begin
        data_out  <= req_data[owner*FLIT_W +: FLIT_W];
        last_out  <= req_last[owner] || at_max;
        dest_out  <= dest_reg;
        valid_out <= 1'b1;
        flit_cnt  <= flit_cnt + 1'b1;
        if (release_pkt) begin
          grant      <= '0;
          last_grant <= owner;
        end
      end else if (ready_out) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Randomized self-checking bench: a cycle-level behavioural model of the arbitration rules
// plus per-requester scoreboards of the flit stream, with directed scenarios first.
module tb_noc_inject_arbiter;
  import noc_pkg::*;

  localparam int N    = 4;
  localparam int FW   = 16;
  localparam int DW   = 6;
  localparam int MAXF = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_last, req_ready, grant;
  logic [N*FW-1:0] req_data;
  logic [N*DW-1:0] req_dest;
  logic [FW-1:0]   data_out;
  logic [DW-1:0]   dest_out;
  logic            last_out, valid_out, ready_out, err_trunc;

  always #5 clk = ~clk;

  noc_inject_arbiter #(.NUM_REQ(N), .FLIT_W(FW), .NODE_ID_W(DW), .MAX_FLITS(MAXF)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_dest(req_dest),
    .req_ready(req_ready), .data_out(data_out), .dest_out(dest_out), .last_out(last_out),
    .valid_out(valid_out), .ready_out(ready_out), .grant(grant), .err_trunc(err_trunc)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  flit_t src_q[N][$];
  int    exp_q[N][$];
  bit    gate[N];
  bit    rnd_valid, rnd_ready, hold_lo;
  int    glog[$];
  int    trunc_seen;
  logic [N-1:0] prev_grant;

  // Behavioural model: owner index (-1 = nobody), rotating pointer, output register contents.
  int            m_owner, m_lg, m_cnt, m_src;
  logic [FW-1:0] m_data;
  logic [DW-1:0] m_dest, m_dest_out;
  bit            m_vout, m_last, m_err;

  logic [N-1:0]    s_valid, s_last;
  logic [N*FW-1:0] s_data;
  logic [N*DW-1:0] s_dest;
  logic            s_ready;

  function automatic void m_reset();
    m_owner = -1; m_lg = N - 1; m_cnt = 0; m_src = 0;
    m_data = '0; m_dest = '0; m_dest_out = '0;
    m_vout = 0; m_last = 0; m_err = 0;
  endfunction

  function automatic void model_update();
    bit acc, tr, found;
    int o;
    acc = 0; tr = 0; found = 0;
    o = m_owner;
    m_err = 0;
    if (o < 0) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_lg + k) % N;
        if (!found && s_valid[idx]) begin
          found = 1; m_owner = idx; m_cnt = 0; m_dest = s_dest[idx*DW +: DW];
        end
      end
    end else begin
      acc = s_valid[o] && (!m_vout || s_ready);
    end
    if (acc) begin
      m_cnt++;
      tr = !s_last[o] && (m_cnt == MAXF);
      m_data = s_data[o*FW +: FW];
      m_last = s_last[o] || tr;
      m_dest_out = m_dest;
      m_vout = 1;
      m_src = o;
      m_err = tr;
      if (s_last[o] || tr) begin
        m_lg = o;
        m_owner = -1;
      end
    end else if (s_ready) begin
      m_vout = 0;
    end
  endfunction

  task automatic push_packet(input int i, input int n, input logic [FW-1:0] base, input logic [DW-1:0] dest);
    flit_t f;
    for (int k = 0; k < n; k++) begin
      f.data = FW'(base + FW'(k));
      f.last = (k == n - 1);
      f.dest = dest;
      src_q[i].push_back(f);
      exp_q[i].push_back(int'(f.data));
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && !gate[i] && (!rnd_valid || $urandom_range(9) != 0)) begin
        req_valid[i]          = 1'b1;
        req_data[i*FW +: FW]  = src_q[i][0].data;
        req_last[i]           = src_q[i][0].last;
        req_dest[i*DW +: DW]  = src_q[i][0].dest;
      end else begin
        req_valid[i]          = 1'b0;
        req_data[i*FW +: FW]  = FW'($urandom);
        req_last[i]           = 1'($urandom);
        req_dest[i*DW +: DW]  = DW'($urandom);
      end
    end
    ready_out = hold_lo ? 1'b0 : (rnd_ready ? ($urandom_range(3) != 0) : 1'b1);
  endtask

  // One clock: drive after the edge, compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    int exp_rdy, gidx;
    drive();
    @(negedge clk);
    s_valid = req_valid; s_last = req_last; s_data = req_data; s_dest = req_dest; s_ready = ready_out;
    exp_rdy = (m_owner >= 0 && (!m_vout || s_ready)) ? (1 << m_owner) : 0;
    check_val("grant", 32'(grant), 32'((m_owner < 0) ? 0 : (1 << m_owner)));
    check_val("req_ready", 32'(req_ready), 32'(exp_rdy));
    check_val("valid_out", 32'(valid_out), 32'(m_vout));
    check_val("err_trunc", 32'(err_trunc), 32'(m_err));
    check_val("data_out", 32'(data_out), 32'(m_data));
    check_val("last_out", 32'(last_out), 32'(m_last));
    check_val("dest_out", 32'(dest_out), 32'(m_dest_out));
    if (err_trunc) trunc_seen++;
    if (grant != 0 && prev_grant == 0) begin
      gidx = -1;
      for (int i = 0; i < N; i++) if (grant[i]) gidx = i;
      glog.push_back(gidx);
    end
    prev_grant = grant;
    if (valid_out && ready_out && m_vout) begin
      check_val("sb_nonempty", 32'(exp_q[m_src].size() > 0), 32'(1));
      if (exp_q[m_src].size() > 0) check_val("sb_data", 32'(data_out), 32'(exp_q[m_src].pop_front()));
    end
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic bit any_src();
    bit a;
    a = 0;
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) a = 1;
    return a;
  endfunction

  task automatic drain(input int budget);
    int c;
    c = 0;
    while ((any_src() || valid_out || m_owner >= 0) && c < budget) begin
      step();
      c++;
    end
    check_val("drain_timeout", 32'(c < budget), 32'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_valid"}, 32'(valid_out), 32'(0));
    check_val({tag, "_last"}, 32'(last_out), 32'(0));
    check_val({tag, "_err"}, 32'(err_trunc), 32'(0));
    check_val({tag, "_grant"}, 32'(grant), 32'(0));
    check_val({tag, "_rdy"}, 32'(req_ready), 32'(0));
    check_val({tag, "_data"}, 32'(data_out), 32'(0));
    check_val({tag, "_dest"}, 32'(dest_out), 32'(0));
  endtask

  initial begin
    int c;
    logic [FW-1:0] held;
    rst_n = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0; req_dest = '0; ready_out = 1'b0;
    rnd_valid = 0; rnd_ready = 0; hold_lo = 0; trunc_seen = 0; prev_grant = '0;
    for (int i = 0; i < N; i++) gate[i] = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Single packet from requester 0.
    push_packet(0, 3, 16'hA001, 6'h05);
    step();
    check_val("sp_grant", 32'(grant), 32'(4'b0001));
    drain(50);
    check_val("sp_tail_data", 32'(data_out), 32'(16'hA003));
    check_val("sp_tail_last", 32'(last_out), 32'(1));
    check_val("sp_dest", 32'(dest_out), 32'(6'h05));

    // Backpressure mid-packet on requester 2.
    push_packet(2, 5, 16'hB001, 6'h12);
    c = 0;
    while (src_q[2].size() > 3 && c < 20) begin step(); c++; end
    check_val("bp_reach", 32'(c < 20), 32'(1));
    held = data_out;
    hold_lo = 1;
    repeat (5) begin
      step();
      check_val("bp_hold", 32'(data_out), 32'(held));
      check_val("bp_rdy", 32'(req_ready), 32'(0));
    end
    hold_lo = 0;
    drain(50);

    // Lock hold: requester 1 stalls mid-packet while requester 2 waits.
    glog.delete();
    push_packet(1, 3, 16'hC001, 6'h21);
    push_packet(2, 2, 16'hD001, 6'h22);
    c = 0;
    while (src_q[1].size() > 2 && c < 20) begin step(); c++; end
    check_val("lock_reach", 32'(c < 20), 32'(1));
    gate[1] = 1;
    repeat (4) begin
      step();
      check_val("lock_grant", 32'(grant), 32'(4'b0010));
    end
    gate[1] = 0;
    drain(60);
    check_val("lock_order_n", 32'(glog.size()), 32'(2));
    check_val("lock_first", 32'(glog[0]), 32'(1));
    check_val("lock_second", 32'(glog[1]), 32'(2));

    // Runaway packet: 20 flits, tail only on the last one.
    trunc_seen = 0;
    push_packet(3, 20, 16'hE000, 6'h33);
    drain(100);
    check_val("trunc_pulses", 32'(trunc_seen), 32'(1));

    // Async reset during flit 2, then round-robin from requester 0.
    push_packet(0, 4, 16'hF001, 6'h01);
    c = 0;
    while (src_q[0].size() > 2 && c < 20) begin step(); c++; end
    check_val("rst_reach", 32'(c < 20), 32'(1));
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    m_reset();
    for (int i = 0; i < N; i++) begin src_q[i].delete(); exp_q[i].delete(); end
    prev_grant = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    glog.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push_packet(i, 1, FW'(16'h5000 + 16 * r + i), DW'(i));
    drain(100);
    check_val("rr_n", 32'(glog.size()), 32'(8));
    for (int k = 0; k < 8; k++) check_val("rr_order", 32'(glog[k]), 32'(k % N));

    // Random traffic with random backpressure and valid gaps.
    rnd_valid = 1; rnd_ready = 1;
    repeat (1500) begin
      if ($urandom_range(3) == 0) begin
        int i;
        i = $urandom_range(N - 1);
        if (src_q[i].size() < 40)
          push_packet(i, $urandom_range(1, MAXF + 4), FW'($urandom), DW'($urandom));
      end
      step();
    end
    rnd_valid = 0; rnd_ready = 0;
    drain(3000);
    for (int i = 0; i < N; i++) check_val("sb_left", 32'(exp_q[i].size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
